// File: rtl/approx_metrics_pkg.sv
// Shared state encodings and derived widths for approximate-adder characterisation blocks.
// The width helpers let every block size its error-distance and sum buses from the same rules.
package approx_metrics_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } acc_state_t;

    // An error distance needs one bit more than the operands, matching the exact sum with carry-out.
    function automatic int ed_width(input int width);
        return width + 1;
    endfunction

    // Sized so that the maximum sample count times the maximum error distance cannot overflow.
    function automatic int sum_width(input int width, input int count_width);
        return width + count_width + 1;
    endfunction

endpackage

// File: rtl/error_distance.sv
// Purpose: unsigned absolute difference between the exact sum and the zero-extended approximate result.
// Latency: combinational. Backpressure: none, this block has no handshake.
module error_distance
    import approx_metrics_pkg::*;
#(
    parameter int width = 16
) (
    input  logic [width:0]   exact,
    input  logic [width-1:0] approx,
    output logic [width:0]   ed
);

    logic [width:0] approx_ext;

    assign approx_ext = {1'b0, approx};
    assign ed = (exact >= approx_ext) ? (exact - approx_ext) : (approx_ext - exact);

endmodule

// File: rtl/error_metrics_accumulator.sv
// Purpose: accumulates error-count, sum and maximum error distance over a run of num_samples_i pairs.
// Latency: 1 cycle from accepted sample to updated results. Backpressure: ready_o high only while running.
module error_metrics_accumulator
    import approx_metrics_pkg::*;
#(
    parameter int width       = 16,
    parameter int count_width = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 start_i,
    input  logic [count_width-1:0]               num_samples_i,
    input  logic                                 valid_i,
    input  logic [width:0]                       exact_i,
    input  logic [width-1:0]                     approx_i,
    output logic                                 ready_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [count_width-1:0]               sample_count_o,
    output logic [count_width-1:0]               err_count_o,
    output logic [sum_width(width, count_width)-1:0] sum_ed_o,
    output logic [ed_width(width)-1:0]           max_ed_o
);

    localparam int ed_w  = ed_width(width);
    localparam int sum_w = sum_width(width, count_width);

    acc_state_t             state_q, state_d;
    logic [count_width-1:0] target_q;
    logic [count_width-1:0] count_inc;
    logic [ed_w-1:0]        ed;
    logic                   accept;
    logic                   last_sample;

    error_distance #(.width(width)) u_error_distance (
        .exact  (exact_i),
        .approx (approx_i),
        .ed     (ed)
    );

    // A start in the same cycle as a valid sample wins: the sample belongs to the abandoned run.
    assign accept      = valid_i && (state_q == ST_RUN) && !start_i;
    assign count_inc   = sample_count_o + count_width'(1);
    assign last_sample = accept && (count_inc == target_q);

    assign ready_o = (state_q == ST_RUN);
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = (num_samples_i == '0) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_RUN && last_sample) begin
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            target_q       <= '0;
            sample_count_o <= '0;
            err_count_o    <= '0;
            sum_ed_o       <= '0;
            max_ed_o       <= '0;
        end else if (start_i) begin
            target_q       <= num_samples_i;
            sample_count_o <= '0;
            err_count_o    <= '0;
            sum_ed_o       <= '0;
            max_ed_o       <= '0;
        end else if (accept) begin
            sample_count_o <= count_inc;
            sum_ed_o       <= sum_ed_o + sum_w'(ed);
            if (ed != '0) begin
                err_count_o <= err_count_o + count_width'(1);
            end
            if (ed > max_ed_o) begin
                max_ed_o <= ed;
            end
        end
    end

endmodule

// File: tb/tb_error_metrics_accumulator.sv
// Self-checking bench: directed scenarios plus randomized runs against a behavioural run model.
module tb_error_metrics_accumulator;

    localparam int W  = 16;
    localparam int CW = 16;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            start_i;
    logic [CW-1:0]   num_samples_i;
    logic            valid_i;
    logic [W:0]      exact_i;
    logic [W-1:0]    approx_i;
    logic            ready_o;
    logic            busy_o;
    logic            done_o;
    logic [CW-1:0]   sample_count_o;
    logic [CW-1:0]   err_count_o;
    logic [W+CW:0]   sum_ed_o;
    logic [W:0]      max_ed_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t       m_mode;
    longint      m_cnt, m_err, m_sum, m_max, m_target;

    error_metrics_accumulator #(.width(W), .count_width(CW)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .num_samples_i  (num_samples_i),
        .valid_i        (valid_i),
        .exact_i        (exact_i),
        .approx_i       (approx_i),
        .ready_o        (ready_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .sample_count_o (sample_count_o),
        .err_count_o    (err_count_o),
        .sum_ed_o       (sum_ed_o),
        .max_ed_o       (max_ed_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_target = 0;
    endtask

    // What one rising edge does to a run, stated in terms of the run rather than any state machine.
    task automatic model_edge(input bit st, input longint num, input bit v, input longint ex, input longint ap);
        longint ed;
        ed = (ex > ap) ? ex - ap : ap - ex;
        if (st) begin
            m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0;
            m_target = num;
            m_mode = (num == 0) ? M_DONE : M_RUN;
        end else if (m_mode == M_RUN && v) begin
            m_cnt++;
            m_sum += ed;
            if (ed != 0) m_err++;
            if (ed > m_max) m_max = ed;
            if (m_cnt == m_target) m_mode = M_DONE;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ready"}, ready_o, m_mode == M_RUN);
        check({tag, ".busy"},  busy_o,  m_mode == M_RUN);
        check({tag, ".done"},  done_o,  m_mode == M_DONE);
        check({tag, ".count"}, sample_count_o, m_cnt);
        check({tag, ".err"},   err_count_o, m_err);
        check({tag, ".sum"},   sum_ed_o, m_sum);
        check({tag, ".max"},   max_ed_o, m_max);
    endtask

    // Called at a falling edge: drive, let one rising edge happen, then check at the next falling edge.
    task automatic cycle(input string tag, input bit st, input int num, input bit v,
                         input longint ex, input longint ap);
        start_i       = st;
        num_samples_i = CW'(num);
        valid_i       = v;
        exact_i       = (W+1)'(ex);
        approx_i      = W'(ap);
        @(posedge clk_i);
        model_edge(st, num, v, ex, ap);
        @(negedge clk_i);
        check_outputs(tag);
    endtask

    initial begin
        longint ex, ap;
        int     num, budget;

        model_reset();
        rst_n_i = 1'b0; start_i = 1'b0; num_samples_i = '0; valid_i = 1'b0;
        exact_i = '0; approx_i = '0;
        #2;
        check_outputs("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        cycle("idle_valid", 0, 0, 1, 17'h00123, 16'h0001);

        // Three pairs with error distances 0, 16, 2.
        cycle("d3_start", 1, 3, 0, 0, 0);
        cycle("d3_s0", 0, 0, 1, 17'h00010, 16'h0010);
        cycle("d3_s1", 0, 0, 1, 17'h10000, 16'hFFF0);
        cycle("d3_s2", 0, 0, 1, 17'h00005, 16'h0007);
        check("d3_err_const",   err_count_o, 2);
        check("d3_sum_const",   sum_ed_o, 18);
        check("d3_max_const",   max_ed_o, 16);
        check("d3_count_const", sample_count_o, 3);
        check("d3_done_const",  done_o, 1);

        // Empty run finishes immediately and never offers ready.
        cycle("z_start", 1, 0, 1, 17'h00009, 16'h0000);
        check("z_done_const", done_o, 1);
        cycle("z_hold", 0, 0, 1, 17'h00009, 16'h0000);

        // Gapped input, extreme distance, then valid while done.
        cycle("g_start", 1, 2, 0, 0, 0);
        cycle("g_s0",  0, 0, 1, 17'h00001, 16'h0000);
        cycle("g_gap0", 0, 0, 0, 17'h1FFFF, 16'h0000);
        cycle("g_gap1", 0, 0, 0, 17'h1FFFF, 16'h0000);
        cycle("g_s1",  0, 0, 1, 17'h1FFFF, 16'h0000);
        check("g_sum_const", sum_ed_o, 64'h20000);
        check("g_max_const", max_ed_o, 64'h1FFFF);
        cycle("g_done_valid", 0, 0, 1, 17'h00000, 16'hFFFF);
        check("g_sum_hold_const", sum_ed_o, 64'h20000);

        // Restart with a coincident sample after two of four.
        cycle("r_start", 1, 4, 0, 0, 0);
        cycle("r_s0", 0, 0, 1, 17'h00003, 16'h0001);
        cycle("r_s1", 0, 0, 1, 17'h00007, 16'h0001);
        cycle("r_restart", 1, 4, 1, 17'h00100, 16'h0000);
        check("r_count_zero_const", sample_count_o, 0);
        check("r_busy_const", busy_o, 1);
        for (int i = 0; i < 4; i++) cycle("r_new", 0, 0, 1, 64'(i + 5), 64'(i));
        check("r_done_const", done_o, 1);
        check("r_count_const", sample_count_o, 4);

        // Asynchronous reset in the middle of a run with nonzero results.
        cycle("a_start", 1, 10, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("a_s", 0, 0, 1, 17'h00050, 16'h0010);
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        check_outputs("after_rst");
        for (int i = 0; i < 3; i++) cycle("post_rst_idle", 0, 0, 1, 17'h00077, 16'h0001);

        // Randomized runs with gaps, occasional restarts and idle-in-done traffic.
        for (int run = 0; run < 40; run++) begin
            num = $urandom_range(0, 12);
            cycle("rnd_start", 1, num, $urandom_range(0, 1), $urandom_range(0, 17'h1FFFF), $urandom_range(0, 16'hFFFF));
            budget = 200;
            while (m_mode == M_RUN && budget > 0) begin
                budget--;
                ex = $urandom_range(0, 17'h1FFFF);
                ap = ($urandom_range(0, 3) == 0) ? (ex & 64'hFFFF) : 64'($urandom_range(0, 16'hFFFF));
                if ($urandom_range(0, 30) == 0)
                    cycle("rnd_restart", 1, $urandom_range(0, 6), 1, ex, ap);
                else
                    cycle("rnd_run", 0, 0, $urandom_range(0, 2) != 0, ex, ap);
            end
            check("rnd_budget", budget > 0, 1);
            for (int i = 0; i < 2; i++)
                cycle("rnd_done_valid", 0, 0, 1, $urandom_range(0, 17'h1FFFF), $urandom_range(0, 16'hFFFF));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/error_metrics_accumulator.md
ERROR_METRICS_ACCUMULATOR -- requirements
Module: error_metrics_accumulator

Interface
REQ-001 SHALL have parameter width, default 16, operand width of the approximate adder under characterisation.
REQ-002 SHALL have parameter count_width, default 16, width of sample counters.
REQ-003 SHALL have port clk_i  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  clear accumulators, begin run.
REQ-006 SHALL have port num_samples_i  input  count_width  samples per run, sampled when start_i is accepted.
REQ-007 SHALL have port valid_i  input  1  sample pair present.
REQ-008 SHALL have port exact_i  input  width+1  exact sum including carry-out.
REQ-009 SHALL have port approx_i  input  width  approximate adder result_o, zero-extended internally.
REQ-010 SHALL have port ready_o  output  1  sample accepted this cycle when valid_i high.
REQ-011 SHALL have port busy_o  output  1  run in progress.
REQ-012 SHALL have port done_o  output  1  run complete, results final.
REQ-013 SHALL have port sample_count_o  output  count_width  samples accepted this run.
REQ-014 SHALL have port err_count_o  output  count_width  samples with nonzero error distance.
REQ-015 SHALL have port sum_ed_o  output  width+count_width+1  sum of error distances.
REQ-016 SHALL have port max_ed_o  output  width+1  largest error distance this run.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL compute error distance ED = |exact_i - {1'b0, approx_i}|, width+1 bits, unsigned, no truncation.
REQ-019 SHALL, on start_i high in IDLE or DONE, clear all counters/accumulators, latch num_samples_i, go to RUN; if num_samples_i == 0, go to DONE instead.
REQ-020 SHALL drive ready_o = 1 only in RUN; busy_o = 1 only in RUN; done_o = 1 only in DONE (level, held until next start_i or reset).
REQ-021 SHALL accept a sample when valid_i && ready_o: sample_count +1, sum_ed += ED, err_count +1 if ED != 0, max_ed = max(max_ed, ED); all updates visible the following cycle (latency 1).
REQ-022 SHALL transition RUN -> DONE on the edge accepting the sample that makes sample_count equal the latched count; done_o and final values appear together the next cycle.
REQ-023 SHALL ignore valid_i in IDLE and DONE (no accumulator change).
REQ-024 SHALL, on start_i high in RUN, restart: clear, re-latch num_samples_i, stay in RUN (or go DONE if zero); a simultaneous valid_i sample is discarded.
REQ-025 SHALL tolerate arbitrary gaps in valid_i; no accumulator overflow is possible since sum_ed_o width covers (2^count_width - 1) * (2^(width+1) - 1).

Reset
REQ-026 SHALL, while rst_n_i low, force state IDLE and all outputs and accumulators to 0, independent of clk_i.
REQ-027 SHALL, on reset assertion mid-run, discard the partial run; after deassertion remain in IDLE until start_i.

Structure
REQ-028 SHALL place FSM state encodings and derived width constants (ED width, sum width) in shared package approx_metrics_pkg.
REQ-029 SHALL instantiate one combinational sub-module error_distance (inputs exact, approx; output ED) reusable by other characterisation blocks.

Verification
REQ-030 SHALL verify reset: rst_n_i low mid-run with nonzero accumulators -> all outputs 0, ready_o 0, state IDLE immediately.
REQ-031 SHALL verify width=16, num_samples 3, pairs (0x00010,0x0010),(0x10000,0xFFF0),(0x00005,0x0007) -> err_count_o 2, sum_ed_o 18, max_ed_o 16, sample_count_o 3, done_o 1 cycle after third accept.
REQ-032 SHALL verify num_samples_i 0 with start_i -> done_o 1 next cycle, all results 0, ready_o never high.
REQ-033 SHALL verify gapped valid_i (accept, 2 idle, accept) over num_samples 2 with ED 1 and 0x1FFFF -> sum_ed_o 0x20000, max_ed_o 0x1FFFF; valid_i in DONE leaves results unchanged.
REQ-034 SHALL verify start_i and valid_i together after 2 of 4 samples -> counters 0 next cycle, busy_o 1, sample dropped, new run completes with 4 further samples.
